// File: rtl/term_write_ctrl.sv
// term_write_ctrl: buffers CPU character writes in a small FIFO, decodes control
// codes, tracks the cursor and scroll origin, and schedules every VRAM write
// (characters, new-line clears, full-screen clears).
// Optional feature macro: TERM_AUTOWRAP_EN -- when defined, a printable character
// that fills the last column wraps the cursor to the next line (scroll + line
// clear, same as CR); when undefined the column saturates at COLS-1.
module term_write_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 24
) (
    input  logic        clk14,
    input  logic        rst,
    input  logic        enable,
    input  logic        w_en,
    input  logic        address,
    input  logic [7:0]  din,
    input  logic        clr_screen,
    output logic [10:0] vram_w_addr,
    output logic [5:0]  vram_w_data,
    output logic        vram_w_en,
    output logic [10:0] cursor_addr,
    output logic [4:0]  start_row,
    output logic        tx_ready,
    output logic        busy,
    output logic        overflow
);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [5:0]  SPACE     = 6'd32;
    localparam logic [11:0] SWEEP_END = 12'd2048;
`ifdef TERM_AUTOWRAP_EN
    localparam bit AUTOWRAP = 1'b1;
`else
    localparam bit AUTOWRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CHAR, LINECLR, SCRCLR} state_t;

    state_t           state;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_q;
    logic             clr_q;
    logic [7:0]       char_q;
    logic [4:0]       cur_row;
    logic [5:0]       cur_col;
    logic [6:0]       clr_col;
    logic [11:0]      sweep;

    logic             wr_c;
    logic             push_edge_c;
    logic             clr_req_c;
    logic             fifo_empty_c;
    logic             fifo_full_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic [7:0]       head_c;
    logic [6:0]       col_inc_c;
    logic [4:0]       adv_row_c;
    logic             scroll_c;
    logic             adv_c;
    logic [5:0]       col_nxt_c;
    logic             goes_idle_c;

    function automatic logic is_cr(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h8D);
    endfunction

    function automatic logic is_ign(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'h0A) || (c == 8'h9B) || (c == 8'h7F);
    endfunction

    assign cursor_addr = {cur_row, cur_col};

    // Edge detection, FIFO handshakes, cursor arithmetic and next-idle decision.
    always_comb begin
        wr_c         = enable & w_en & ~address;
        push_edge_c  = wr_c & ~wr_q;
        clr_req_c    = clr_screen & ~clr_q;
        fifo_empty_c = (count == '0);
        fifo_full_c  = (count == CNT_W'(FIFO_DEPTH));
        head_c       = fifo_mem[rd_ptr];
        pop_c        = (state == IDLE) & ~clr_req_c & ~fifo_empty_c;
        // A push in the clear-request cycle is lost to the flush.
        push_c       = push_edge_c & ~fifo_full_c & ~clr_req_c;
        drop_c       = push_edge_c & fifo_full_c & ~clr_req_c;

        count_nxt = count;
        if (clr_req_c) begin
            count_nxt = '0;
        end else if (push_c && !pop_c) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - CNT_W'(1);
        end

        col_inc_c = {1'b0, cur_col} + 7'd1;
        adv_row_c = cur_row + 5'd1;
        scroll_c  = ((adv_row_c - start_row) == 5'(ROWS));
        adv_c     = is_cr(char_q) |
                    (AUTOWRAP & ~is_ign(char_q) & (col_inc_c == 7'(COLS)));

        col_nxt_c = col_inc_c[5:0];
        if (is_cr(char_q) || is_ign(char_q) || adv_c) begin
            col_nxt_c = '0;
        end else if (col_inc_c == 7'(COLS)) begin
            col_nxt_c = 6'(COLS - 1);
        end

        goes_idle_c = 1'b1;
        case (state)
            IDLE:    goes_idle_c = fifo_empty_c;
            CHAR:    goes_idle_c = ~adv_c;
            LINECLR: goes_idle_c = (clr_col == 7'(COLS));
            SCRCLR:  goes_idle_c = (sweep == SWEEP_END);
            default: goes_idle_c = 1'b1;
        endcase
        if (clr_req_c) begin
            goes_idle_c = 1'b0;
        end
    end

    // FIFO storage (no reset needed on the data array).
    always_ff @(posedge clk14) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy; a clear request flushes.
    always_ff @(posedge clk14 or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (clr_req_c) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Controller FSM: cursor/scroll state and registered VRAM write port.
    always_ff @(posedge clk14 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            clr_q       <= 1'b0;
            char_q      <= '0;
            cur_row     <= '0;
            cur_col     <= '0;
            start_row   <= '0;
            clr_col     <= '0;
            sweep       <= '0;
            vram_w_addr <= '0;
            vram_w_data <= '0;
            vram_w_en   <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_q      <= wr_c;
            clr_q     <= clr_screen;
            tx_ready  <= (count_nxt != CNT_W'(FIFO_DEPTH));
            busy      <= ~goes_idle_c | (count_nxt != '0);
            vram_w_en <= 1'b0;
            if (drop_c) begin
                overflow <= 1'b1;
            end
            if (clr_req_c) begin
                // Enter or restart the full-screen sweep; address 0 goes out now.
                state       <= SCRCLR;
                cur_row     <= '0;
                cur_col     <= '0;
                start_row   <= '0;
                overflow    <= 1'b0;
                sweep       <= 12'd1;
                vram_w_en   <= 1'b1;
                vram_w_addr <= '0;
                vram_w_data <= SPACE;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop_c) begin
                            char_q <= head_c;
                            state  <= CHAR;
                            // The glyph write is issued here so it is on the port during CHAR.
                            if (!is_cr(head_c) && !is_ign(head_c)) begin
                                vram_w_en   <= 1'b1;
                                vram_w_addr <= {cur_row, cur_col};
                                vram_w_data <= {~head_c[6], head_c[4:0]};
                            end
                        end
                    end
                    CHAR: begin
                        cur_col <= col_nxt_c;
                        if (adv_c) begin
                            cur_row <= adv_row_c;
                            if (scroll_c) begin
                                start_row <= start_row + 5'd1;
                            end
                            clr_col     <= 7'd1;
                            vram_w_en   <= 1'b1;
                            vram_w_addr <= {adv_row_c, 6'd0};
                            vram_w_data <= SPACE;
                            state       <= LINECLR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    LINECLR: begin
                        if (clr_col == 7'(COLS)) begin
                            state <= IDLE;
                        end else begin
                            vram_w_en   <= 1'b1;
                            vram_w_addr <= {cur_row, clr_col[5:0]};
                            vram_w_data <= SPACE;
                            clr_col     <= clr_col + 7'd1;
                        end
                    end
                    SCRCLR: begin
                        if (sweep == SWEEP_END) begin
                            state <= IDLE;
                        end else begin
                            vram_w_en   <= 1'b1;
                            vram_w_addr <= sweep[10:0];
                            vram_w_data <= SPACE;
                            sweep       <= sweep + 12'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_term_write_ctrl.sv
// Testbench for term_write_ctrl: directed scenarios plus randomized character
// traffic, scored against a character-level terminal model.
`timescale 1ns/1ps
module tb_term_write_ctrl;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned COLS       = 40;
    localparam int unsigned ROWS       = 24;

    logic        clk14 = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        w_en = 1'b0;
    logic        address = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        clr_screen = 1'b0;
    logic [10:0] vram_w_addr;
    logic [5:0]  vram_w_data;
    logic        vram_w_en;
    logic [10:0] cursor_addr;
    logic [4:0]  start_row;
    logic        tx_ready;
    logic        busy;
    logic        overflow;

    term_write_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk14(clk14), .rst(rst), .enable(enable), .w_en(w_en), .address(address),
        .din(din), .clr_screen(clr_screen), .vram_w_addr(vram_w_addr),
        .vram_w_data(vram_w_data), .vram_w_en(vram_w_en), .cursor_addr(cursor_addr),
        .start_row(start_row), .tx_ready(tx_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk14 = ~clk14;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [16:0] exp_q[$];
    logic [7:0]  pend_q[$];
    logic [16:0] mon_e;
    int          m_row = 0;
    int          m_col = 0;
    int          m_start = 0;
    logic [7:0]  ign_codes [4] = '{8'h00, 8'h0A, 8'h9B, 8'h7F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected no such event", name, act);
    endtask

    // Terminal model: new line moves down, scrolls once the window is full, blanks the line.
    task automatic model_row_adv();
        m_row = (m_row + 1) % 32;
        if (((m_row - m_start + 32) % 32) == ROWS) m_start = (m_start + 1) % 32;
        for (int c = 0; c < COLS; c++) exp_q.push_back({5'(m_row), 6'(c), 6'd32});
    endtask

    task automatic model_char(input logic [7:0] c);
        int g;
        if (c == 8'h0D || c == 8'h8D) begin
            m_col = 0;
            model_row_adv();
        end else if (c == 8'h00 || c == 8'h0A || c == 8'h9B || c == 8'h7F) begin
            m_col = 0;
        end else begin
            g = (c[6] ? 0 : 32) + (int'(c) % 32);
            exp_q.push_back({5'(m_row), 6'(m_col), 6'(g)});
            m_col++;
            if (m_col == COLS) begin
`ifdef TERM_AUTOWRAP_EN
                m_col = 0;
                model_row_adv();
`else
                m_col = COLS - 1;
`endif
            end
        end
    endtask

    task automatic expand_one();
        logic [7:0] c;
        c = pend_q.pop_front();
        model_char(c);
    endtask

    task automatic model_clear();
        exp_q.delete();
        pend_q.delete();
        m_row = 0; m_col = 0; m_start = 0;
        for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), 6'd32});
    endtask

    // Monitor: every VRAM write must be the next one the model expects.
    always @(negedge clk14) begin
        if (!rst && vram_w_en) begin
            while (exp_q.size() == 0 && pend_q.size() != 0) expand_one();
            if (exp_q.size() == 0) begin
                fail("unexpected_write", 32'({vram_w_addr, vram_w_data}));
            end else begin
                mon_e = exp_q.pop_front();
                check("vram_write", 32'({vram_w_addr, vram_w_data}), 32'(mon_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk14);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; w_en = 1'b0; address = 1'b0; din = 8'h00; clr_screen = 1'b0;
        exp_q.delete(); pend_q.delete();
        m_row = 0; m_col = 0; m_start = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_raw(input logic [7:0] c, input int hold, output logic rdy, output logic ovf);
        enable = 1'b1; w_en = 1'b1; address = 1'b0; din = c;
        repeat (hold) tick();
        rdy = tx_ready;
        ovf = overflow;
        enable = 1'b0; w_en = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] c, input int hold);
        int n;
        logic rdy, ovf;
        n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin tick(); n++; end
        if (n >= 500) fail("tx_ready_timeout", 32'(tx_ready));
        else begin
            pend_q.push_back(c);
            push_raw(c, hold, rdy, ovf);
        end
    endtask

    task automatic noise();
        int k;
        k = $urandom_range(0, 2);
        enable = (k != 1); w_en = (k != 2); address = (k == 0); din = 8'($urandom_range(0, 255));
        tick();
        enable = 1'b0; w_en = 1'b0; address = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin tick(); n++; end
        if (n >= limit) fail("busy_timeout", 32'(busy));
    endtask

    task automatic quiesce(input string tag);
        while (pend_q.size() != 0) expand_one();
        check({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({tag, "_cursor_addr"}, 32'(cursor_addr), 32'({5'(m_row), 6'(m_col)}));
        check({tag, "_start_row"}, 32'(start_row), 32'(m_start));
    endtask

    task automatic clear_pulse();
        clr_screen = 1'b1;
        @(posedge clk14);
        model_clear();
        #1 clr_screen = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return ($urandom_range(0, 1) == 1) ? 8'h8D : 8'h0D;
        if (k == 1) return ign_codes[$urandom_range(0, 3)];
        return {1'($urandom_range(0, 1)), 7'($urandom_range(32, 126))};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy, ovf;

        // Reset values
        do_reset();
        check("rst_w_en", 32'(vram_w_en), 32'd0);
        check("rst_w_addr", 32'(vram_w_addr), 32'd0);
        check("rst_w_data", 32'(vram_w_data), 32'd0);
        check("rst_cursor", 32'(cursor_addr), 32'd0);
        check("rst_start_row", 32'(start_row), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // First character: write lands exactly two cycles after the edge
        pend_q.push_back(8'h41);
        enable = 1'b1; w_en = 1'b1; address = 1'b0; din = 8'h41;
        @(negedge clk14);
        check("first_t0_w_en", 32'(vram_w_en), 32'd0);
        @(negedge clk14);
        enable = 1'b0; w_en = 1'b0;
        check("first_t1_w_en", 32'(vram_w_en), 32'd0);
        check("first_t1_busy", 32'(busy), 32'd1);
        @(negedge clk14);
        check("first_t2_w_en", 32'(vram_w_en), 32'd1);
        @(negedge clk14);
        check("first_cursor", 32'(cursor_addr), 32'h001);
        tick();
        wait_idle(100);
        quiesce("first");

        // CR at column 5: line clear of row 1, busy timing
        for (int i = 0; i < 4; i++) send(8'(8'h42 + i), 1);
        wait_idle(200);
        quiesce("pre_cr");
        check("pre_cr_cursor", 32'(cursor_addr), 32'h005);
        pend_q.push_back(8'h8D);
        enable = 1'b1; w_en = 1'b1; address = 1'b0; din = 8'h8D;
        for (int k = 0; k <= 43; k++) begin
            @(negedge clk14);
            if (k == 1) begin enable = 1'b0; w_en = 1'b0; end
            if (k == 42) check("cr_busy_hold", 32'(busy), 32'd1);
            if (k == 43) check("cr_busy_release", 32'(busy), 32'd0);
        end
        tick();
        quiesce("cr");
        check("cr_cursor", 32'(cursor_addr), 32'h040);

        // 24 CRs from reset: scroll begins on the 24th
        do_reset();
        repeat (23) send(8'h0D, 1);
        wait_idle(3000);
        check("scroll_before", 32'(start_row), 32'd0);
        send(8'h0D, 1);
        wait_idle(200);
        quiesce("scroll");
        check("scroll_start_row", 32'(start_row), 32'd1);
        check("scroll_cursor", 32'(cursor_addr), 32'h600);

        // Clear request with characters queued: restart flushes them
        send(8'h41, 1);
        wait_idle(100);
        clear_pulse();
        for (int i = 0; i < 5; i++) begin
            pend_q.push_back(8'(8'h50 + i));
            push_raw(8'(8'h50 + i), 1, rdy, ovf);
        end
        clear_pulse();
        wait_idle(5000);
        quiesce("clr");
        check("clr_cursor", 32'(cursor_addr), 32'd0);
        check("clr_tx_ready", 32'(tx_ready), 32'd1);

        // Overflow: 9 pushes during a sweep with an 8-deep FIFO
        clear_pulse();
        for (int i = 0; i < 9; i++) begin
            push_raw(8'(8'h61 + i), 1, rdy, ovf);
            if (i < 8) pend_q.push_back(8'(8'h61 + i));
            if (i == 6) check("ovf_tx_ready_7th", 32'(rdy), 32'd1);
            if (i == 7) check("ovf_tx_ready_8th", 32'(rdy), 32'd0);
            if (i == 7) check("ovf_before_9th", 32'(ovf), 32'd0);
            if (i == 8) check("ovf_after_9th", 32'(ovf), 32'd1);
        end
        wait_idle(5000);
        quiesce("ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear_pulse();
        tick();
        check("ovf_cleared", 32'(overflow), 32'd0);
        wait_idle(5000);
        quiesce("ovf_clr");

        // Reset mid-sweep stops writes immediately
        clear_pulse();
        repeat (100) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_w_en", 32'(vram_w_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        do_reset();

        // 41 printable characters from column 0
        for (int i = 0; i < 41; i++) send(8'(8'h41 + (i % 26)), 1);
        wait_idle(500);
        quiesce("wrap");
`ifdef TERM_AUTOWRAP_EN
        check("wrap_cursor", 32'(cursor_addr), 32'h041);
`else
        check("wrap_cursor", 32'(cursor_addr), 32'h027);
`endif

        // Randomized traffic with strobe noise and held strobes
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op == 0) noise();
            else if (op == 1) send(rand_char(), $urandom_range(2, 4));
            else send(rand_char(), 1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
            if (i % 60 == 59) begin
                wait_idle(5000);
                quiesce("rand");
            end
        end
        wait_idle(5000);
        quiesce("final");
        check("final_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/term_write_ctrl.md
# term_write_ctrl

Write-side controller for the 40×24 text display VRAM (2048×6, address = {row[4:0], col[5:0]}). Buffers CPU character writes in a small FIFO, interprets control codes, maintains the hardware cursor and scroll origin, and schedules every VRAM write port access: character writes, new-line clears and full-screen clears. The scanout side reads VRAM independently and only consumes `cursor_addr` and `start_row` from this block.

## Interface
- `FIFO_DEPTH`, 8: character FIFO entries; power of two, 2..32.
- `COLS`, 40: visible columns per row, ≤ 64.
- `ROWS`, 24: visible rows, ≤ 31.

Ports:
- `clk14`  in  1  system clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `enable`  in  1  CPU bus cycle strobe.
- `w_en`  in  1  CPU write strobe.
- `address`  in  1  register select; 0 = TX data register.
- `din`  in  8  CPU write data.
- `clr_screen`  in  1  clear-screen request, level input.
- `vram_w_addr`  out  11  VRAM write address {row, col}.
- `vram_w_data`  out  6  VRAM write data.
- `vram_w_en`  out  1  VRAM write strobe, one cycle per cell.
- `cursor_addr`  out  11  current cursor cell {cur_row, cur_col}.
- `start_row`  out  5  VRAM row shown on the top visible line.
- `tx_ready`  out  1  FIFO not full.
- `busy`  out  1  high whenever the FSM is not IDLE or the FIFO is non-empty.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.

## Operation
- Capture: `wr = enable & w_en & ~address`. A 0→1 transition of `wr` pushes `din` into the FIFO. Holding `wr` high pushes once only. A push while full is dropped and sets `overflow`.
- Clear request: a 0→1 transition of `clr_screen`.
- Priority, evaluated every cycle: clear request > current LINECLR/SCRCLR > FIFO pop.
- FSM states and transitions:
  - IDLE: on a clear request, go to SCRCLR. Otherwise, if the FIFO is non-empty, pop one entry and go to CHAR.
  - CHAR: one cycle. Decode the popped byte `c`:
    - 0x0D or 0x8D: `cur_col` = 0, then do a row advance.
    - 0x00, 0x0A, 0x9B or 0x7F: `cur_col` = 0, no write, return to IDLE.
    - Any other byte: write `{~c[6], c[4:0]}` at `{cur_row, cur_col}` and increment `cur_col`. If the new column equals `COLS`, wrap (see Configuration). Otherwise return to IDLE.
  - Row advance: `cur_row` += 1 (mod 32). If `(new cur_row − start_row) mod 32 == ROWS`, then `start_row` += 1 in the same cycle. Go to LINECLR with `clr_col` = 0.
  - LINECLR: write 6'd32 at `{cur_row, clr_col}` for `clr_col` = 0..`COLS`−1, one write per cycle, then return to IDLE.
  - SCRCLR: flush the FIFO and clear `overflow`. Set `cur_row`, `cur_col` and `start_row` to 0. Write 6'd32 at addresses 0..2047, one per cycle, then return to IDLE. A new clear request during SCRCLR restarts the sweep at address 0.
- FIFO pushes remain accepted during LINECLR and SCRCLR. Exception: a push in the cycle SCRCLR is entered or restarted is discarded by the flush.
- A push and a pop in the same cycle are both performed and leave the count unchanged.
- Column arithmetic is 6-bit. Row arithmetic is 5-bit and wraps 31→0.

## Timing
- Reset values: `vram_w_addr` 0, `vram_w_data` 0, `vram_w_en` 0, `cursor_addr` 0, `start_row` 0, `tx_ready` 1, `busy` 0, `overflow` 0. FSM is IDLE and the FIFO is empty.
- Reset asserted mid-sweep aborts immediately. No further writes occur, and VRAM contents are not restored.
- `wr` edge sampled at cycle t → FIFO count updates at t+1. If IDLE with the FIFO empty at t+1, the pop occurs at t+1 and `vram_w_en` is high at t+2.
- Each printable character occupies 2 cycles (IDLE + CHAR). CR costs 2 + `COLS` cycles.
- SCRCLR: first write in the cycle after the clear edge is sampled, 2048 consecutive `vram_w_en` cycles.
- `tx_ready` and `busy` are registered and reflect the count after the current cycle's push/pop.
- `cursor_addr` and `start_row` update in the cycle after the causing CHAR, row advance or SCRCLR entry.

## Configuration
- `TERM_AUTOWRAP_EN` defined: when `cur_col` reaches `COLS`, set `cur_col` = 0 and perform a row advance (scroll, LINECLR), exactly as for CR.
- `TERM_AUTOWRAP_EN` undefined: `cur_col` saturates at `COLS`−1. Further printable characters overwrite column `COLS`−1 until a CR or ignored code resets the column.

## Test plan
- Reset, push 0x41 → one write at addr 0x000, data 6'h01, exactly t+2 after the edge; `cursor_addr` = 0x001.
- Push 0x8D at `cursor_addr` 0x005 → 40 writes of 6'd32 at 0x040..0x067; `cursor_addr` = 0x040; `busy` low 42 cycles after the pop.
- 24 CRs from reset → `start_row` becomes 1 on the 24th; row 24 (0x600..0x627) cleared; `cursor_addr` = 0x600.
- Pulse `clr_screen` with 5 chars queued → FIFO empty, 2048 space writes 0x000..0x7FF, `cursor_addr` = 0, `start_row` = 0.
- 9 back-to-back pushes during SCRCLR with `FIFO_DEPTH` = 8 → `tx_ready` low after the 8th, `overflow` = 1, 8 chars written after the sweep.
- 41 printable chars from col 0: with the macro, the 41st lands at 0x040 after a row-1 clear; without it, the 41st overwrites 0x027.
